// File: rtl/mult16_colsum_drain.sv
// ==== mult16_colsum_drain : carry-normalising drain for mult16 column sums ====
// ==== rev 1.0 : initial release                                              ====
`default_nettype none

module mult16_colsum_drain #(
  parameter int FLUSH_LIMBS = 2,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [35:0]      in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_limb,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_ovf
);

  localparam int FC_W = $clog2(FLUSH_LIMBS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [20:0]       carry;
  logic [IDX_W-1:0]  limb_cnt;
  logic [FC_W-1:0]   flush_cnt;
  logic [36:0]       sum;
  logic              load_ok, col_xfer, flush_load, flush_final;

  assign sum     = {1'b0, in_p} + {16'b0, carry};
  assign load_ok = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The operand returns to IDLE as soon as its last flush limb is loaded, so the
  // next operand can start in the same cycle that limb leaves the output register.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    col_xfer    = 1'b0;
    flush_load  = 1'b0;
    flush_final = 1'b0;
    case (state)
      IDLE, RUN: begin
        in_ready = load_ok;
        col_xfer = in_valid && load_ok;
        if (col_xfer && in_last) state_nxt = FLUSH;
        else if (col_xfer)       state_nxt = RUN;
      end
      FLUSH: begin
        flush_load  = load_ok;
        flush_final = (flush_cnt == FC_W'(1));
        if (flush_load && flush_final) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry     <= '0;
      limb_cnt  <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_limb  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (col_xfer) begin
      out_valid <= 1'b1;
      out_limb  <= sum[15:0];
      out_idx   <= limb_cnt;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      carry     <= sum[36:16];
      limb_cnt  <= limb_cnt + 1'b1;
      if (in_last) flush_cnt <= FC_W'(FLUSH_LIMBS);
    end else if (flush_load) begin
      out_valid <= 1'b1;
      out_limb  <= carry[15:0];
      out_idx   <= limb_cnt;
      out_last  <= flush_final;
      out_ovf   <= flush_final && (carry[20:16] != 5'd0);
      if (flush_final) begin
        carry     <= '0;
        limb_cnt  <= '0;
        flush_cnt <= '0;
      end else begin
        carry     <= carry >> 16;
        limb_cnt  <= limb_cnt + 1'b1;
        flush_cnt <= flush_cnt - 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult16_colsum_drain.sv
// ==== tb_mult16_colsum_drain : randomized bench against a big-integer model ====
// ==== rev 1.0 : initial release                                              ====
`default_nettype none

module tb_mult16_colsum_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, out_ovf;
  logic [35:0] in_p;
  logic [15:0] out_limb;
  logic [7:0]  out_idx;
  logic        in1_valid, in1_ready, in1_last, out1_valid, out1_last, out1_ovf;
  logic        out1_ready = 1'b1;
  logic [35:0] in1_p;
  logic [15:0] out1_limb;
  logic [7:0]  out1_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  int max_gap = 0;

  logic [35:0] cols[$];
  logic [25:0] exp_q[$];
  logic [25:0] exp1_q[$];

  always #5 clk = ~clk;

  mult16_colsum_drain #(.FLUSH_LIMBS(2), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_limb(out_limb),
    .out_idx(out_idx), .out_last(out_last), .out_ovf(out_ovf)
  );

  mult16_colsum_drain #(.FLUSH_LIMBS(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_p(in1_p),
    .in_last(in1_last), .out_valid(out1_valid), .out_ready(out1_ready), .out_limb(out1_limb),
    .out_idx(out1_idx), .out_last(out1_last), .out_ovf(out1_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Operand value = sum of cols[i] * 2^(16*i); expected limbs are its base-2^16 digits.
  function automatic void model(input int f, input bit second);
    logic [1023:0] v;
    logic [25:0]   e;
    logic          last, ovf;
    int            n;
    v = '0;
    n = cols.size();
    for (int i = 0; i < n; i++) v = v + ({988'b0, cols[i]} << (16 * i));
    for (int k = 0; k < n + f; k++) begin
      last = (k == n + f - 1);
      ovf  = last && ((v >> (16 * (n + f))) != '0);
      e    = {v[16*k +: 16], 8'(k), last, ovf};
      if (second) exp1_q.push_back(e);
      else        exp_q.push_back(e);
    end
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        check("limb_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check("limb", 64'({out_limb, out_idx, out_last, out_ovf}), 64'(exp_q.pop_front()));
        if (out_last && in_valid) check("b2b_in_ready", 64'(in_ready), 64'd1);
      end
      if (out1_valid) begin
        check("ovf_limb_expected", 64'(exp1_q.size() != 0), 64'd1);
        if (exp1_q.size() != 0)
          check("ovf_limb", 64'({out1_limb, out1_idx, out1_last, out1_ovf}), 64'(exp1_q.pop_front()));
      end
    end
  end

  task automatic send_col(input logic [35:0] p, input logic last);
    int t;
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    t        = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("col_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_p     = {4'($urandom), 32'($urandom)};
  endtask

  task automatic send_operand();
    model(2, 1'b0);
    for (int i = 0; i < cols.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      send_col(cols[i], i == cols.size() - 1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size() + exp1_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rnd_col();
    if ($urandom_range(0, 3) == 0) return 36'hF_FFFF_FFFF;
    return {4'($urandom), 32'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b1;
    in1_valid = 1'b0; in1_p = '0; in1_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_limb",  64'(out_limb),  64'd0);
    check("rst_out_idx",   64'(out_idx),   64'd0);
    check("rst_out_flags", 64'({out_last, out_ovf}), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_in1_ready", 64'(in1_ready), 64'd1);
    @(posedge clk);
    #1;

    cols = '{36'h0_0001_2345};
    send_operand();
    wait_drain();

    cols = '{36'hF_FFFF_FFFF, 36'h0_0000_0001};
    send_operand();
    wait_drain();

    mode = 1;
    cols = '{rnd_col(), rnd_col(), rnd_col(), rnd_col()};
    send_operand();
    wait_drain();

    mode = 0;
    cols = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF};
    send_operand();
    cols = '{36'h0_0000_0007, 36'h0_0000_0009};
    send_operand();
    wait_drain();

    mode    = 2;
    max_gap = 2;
    for (int op = 0; op < 12; op++) begin
      cols.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) cols.push_back(rnd_col());
      send_operand();
    end
    wait_drain();
    max_gap = 0;

    cols = '{36'hF_FFFF_FFFF};
    model(1, 1'b1);
    in1_valid = 1'b1; in1_p = 36'hF_FFFF_FFFF; in1_last = 1'b1;
    @(negedge clk);
    check("ovf_col_accept", 64'(in1_ready), 64'd1);
    @(posedge clk);
    #1 in1_valid = 1'b0;
    wait_drain();

    mode = 3;
    @(posedge clk);
    #2;
    send_col(36'h0_1234_5678, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    mode = 0;
    @(posedge clk);
    #1;
    cols = '{36'h0_0000_ABCD, 36'h0_0003_0000};
    send_operand();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mult16_colsum_drain.md
# mult16_colsum_drain

Reader side of the radix-16 multiplier datapath in the modexp core. It accepts the 36-bit column sums produced by the `mult16` DSP48 multiply-accumulate slices one column per handshake. It propagates the inter-column carry and emits normalised 16-bit result limbs, least-significant first, to the downstream modexp register file. After the last column it flushes the residual carry as a fixed number of extra limbs and marks the final one.

## Interface
Parameters:
- FLUSH_LIMBS, default 2: limbs emitted after the last column to drain the carry (≥1).
- IDX_W, default 8: width of the limb index counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  column sum on in_p is valid.
- in_ready  out  1  block accepts a column this cycle.
- in_p  in  36  unsigned column sum from the multiplier P output.
- in_last  in  1  qualifies in_p as the final (most-significant) column.
- out_valid  out  1  out_limb is valid.
- out_ready  in  1  downstream accepts out_limb.
- out_limb  out  16  normalised result limb.
- out_idx  out  IDX_W  limb index, 0 for the first limb of an operand.
- out_last  out  1  final limb of the operand (last flush limb).
- out_ovf  out  1  valid with out_last: nonzero carry remained after the flush.

## Operation
- Column transfer: in_valid && in_ready. Limb transfer: out_valid && out_ready.
- Carry register `carry` is 21 bits and is zero after reset and after each operand.
- On a column transfer:
  - sum = in_p + carry, computed at 37 bits (no truncation).
  - The output register loads out_limb = sum[15:0] and out_idx = limb counter.
  - carry ← sum[36:16]; the limb counter increments.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: no operand in progress. The first column transfer moves to RUN, or to FLUSH if in_last=1 on that column.
  - RUN: column transfers continue. The transfer with in_last=1 moves to FLUSH.
  - FLUSH: in_ready=0. Emits FLUSH_LIMBS limbs. Each loads out_limb=carry[15:0] and carry ← carry>>16. The flush counter counts down.
    - The last flush limb sets out_last=1 and out_ovf=(carry>>16)!=0, evaluated before the shift.
    - When that limb transfers: → IDLE, with carry, limb counter and flush counter cleared.
- in_ready = (state≠FLUSH) && (!out_valid || out_ready). This is a single output register with pass-through back-pressure and no bubble.
- A FLUSH limb loads only when !out_valid || out_ready.
- The limb counter wraps modulo 2^IDX_W. No error is flagged on wrap.
- out_limb, out_idx, out_last and out_ovf hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_limb=0, out_idx=0, out_last=0, out_ovf=0; in_ready=1 in the cycle after rst deasserts. State=IDLE, carry=0, counters=0.
- Latency is 1 cycle. A column transferred at edge k is presented on out_* after edge k, in cycle k+1.
- Throughput is one limb per cycle with out_ready held high.
- An operand of N columns produces N+FLUSH_LIMBS limbs. The first flush limb follows the last column limb with no gap when unstalled.
- A new operand's first column may transfer in the same cycle the final flush limb transfers. That column sees carry=0 and out_idx=0.
- rst during RUN or FLUSH abandons the operand immediately: no out_last is emitted, and all state returns to reset values at the next edge.
- in_p/in_last are sampled only on a transfer. Values while in_ready=0 are ignored.

## Test plan
- Single column, in_p=36'h0_0001_2345, in_last=1, out_ready=1 → limbs 0x2345 (idx0), 0x0001 (idx1), 0x0000 (idx2, last, ovf=0).
- Carry chain, columns 36'hF_FFFF_FFFF, 36'h0_0000_0001 (last):
  - limb0 = 0xFFFF, carry = 0xFFFFF.
  - limb1 = 0x0000, carry = 0x10.
  - flush: 0x0010, then 0x0000 with last=1.
- Back-pressure, 4 columns with out_ready toggling 1/0 each cycle:
  - in_ready=0 whenever out_valid && !out_ready.
  - No limb is lost or duplicated, and the data matches the reference sum.
- Back-to-back operands: the second operand's first column transfers in the cycle the first operand's last limb transfers → idx restarts at 0, and the carry from the first operand is absent.
- Overflow: FLUSH_LIMBS=1, single column 36'hF_FFFF_FFFF → limbs 0xFFFF, then 0xFFFF with last=1 and ovf=1.
- Reset mid-operation: rst asserted for one cycle while in FLUSH → out_valid=0 the next cycle, in_ready=1, the following operand starts at idx 0 with carry 0.
